div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the execute stage. It is the responder side of the hazard unit's divide stall handshake.
- It accepts a start from the E stage and holds div_ready low until the result is valid. The hazard unit stalls the pipe while start is high and div_ready is low.
- It produces HI (remainder) and LO (quotient) for the HI/LO write path in M.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start_div  in  1  E-stage DIV/DIVU is present. Held high by the pipe until it advances.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled with start_div in IDLE.
- dividend  in  WIDTH  rs operand, forwarded value, sampled in IDLE.
- divisor  in  WIDTH  rt operand, forwarded value, sampled in IDLE.
- hold  in  1  pipeline held by another source (fetch or memory stall).
- annul  in  1  exception flush; abandons any operation in progress.
- div_ready  out  1  result valid this cycle.
- div_busy  out  1  state is BUSY.
- hi_out  out  WIDTH  remainder.
- lo_out  out  WIDTH  quotient.

Behaviour:
- Reset: state goes to IDLE. div_ready=0, div_busy=0, hi_out=0, lo_out=0, counter=0.
- FSM states:
  - IDLE: start_div & ~annul captures |dividend|, |divisor|, sign of quotient, sign of remainder and signed_div.
    - If divisor==0, go to DONE. hi_out=dividend (raw), lo_out={WIDTH{1}}.
    - Otherwise clear the partial remainder, set counter=0, go to BUSY.
  - BUSY: one iteration per cycle.
    - Shift the {rem, quo} pair left by 1 and trial-subtract the divisor from rem.
    - If the result is non-negative, keep it and set the quotient LSB to 1.
    - Increment the counter. When counter==WIDTH-1, go to DONE.
  - DONE: div_ready=1. hi_out/lo_out hold the sign-corrected result.
    - Stay in DONE while hold & ~annul.
    - Otherwise go to IDLE next cycle.
- Output timing: div_ready, hi_out and lo_out are registered. For a non-zero divisor, div_ready rises exactly WIDTH+1 cycles after the IDLE cycle that accepted start (33 for WIDTH=32).
- Sign correction is applied on the BUSY→DONE transition and only when signed_div:
  - lo is negated if the operand signs differ.
  - hi is negated if the dividend is negative.
  - Absolute value uses two's-complement negate, so the most negative value maps to itself as unsigned.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This is a natural wrap; no trap is raised.
- Back-to-back: DONE→IDLE takes one cycle. A start_div asserted in that IDLE cycle is a new instruction and starts a new divide.
- annul:
  - From any state, the next state is IDLE and div_ready=0 the next cycle.
  - hi_out/lo_out keep their last values; the counter is cleared.
  - annul wins over start_div in the same cycle.
- rst mid-operation: same as reset. Reset has priority over annul.
- Operand changes while BUSY are ignored; only the values captured in IDLE are used.
- div_ready is never asserted in IDLE or BUSY.

Decomposition:
- Shared package (cpu_defs):
  - WIDTH default.
  - State encoding DIV_IDLE=2'b00, DIV_BUSY=2'b01, DIV_DONE=2'b10.
  - Divide-by-zero constants DIV0_LO='1 and DIV0_HI=dividend passthrough, noted as the defined behaviour.
- One natural sub-module, div_abs, combinational: given a value and signed_div, returns the magnitude and sign bit. It is instantiated for each operand, and its negate is reused for sign correction. Everything else is one FSM plus a datapath in div_unit.

Test Plan:
- Signed positive/negative: signed_div=1, dividend=7, divisor=0xFFFFFFFE (-2), start held → div_ready high 33 cycles after start; lo=0xFFFFFFFD (-3), hi=0x00000001.
- Signed negative/positive, then unsigned:
  - signed_div=1, 0xFFFFFFF9 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then back-to-back start the next cycle with DIVU 0xFFFFFFFF / 0x10 → lo=0x0FFFFFFF, hi=0xF, again at 33 cycles.
- Overflow and divide-by-zero:
  - Signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 0x1234 / 0 → div_ready on the 2nd cycle, lo=0xFFFFFFFF, hi=0x1234.
- Hold in DONE: hold=1 for 5 cycles after div_ready rises → div_ready stays 1 and the result is stable. hold drops → IDLE next cycle with no restart, even though start_div is still high in that DONE cycle.
- Annul mid-divide: annul pulsed at BUSY iteration 10 → IDLE next cycle, div_ready stays 0, previous hi/lo retained. start in the following cycle → fresh 33-cycle divide with a correct result.
- Reset mid-divide: rst at iteration 20 → next cycle all outputs 0 and state IDLE. Annul and rst asserted together → reset result.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the execute-stage divider.
package cpu_defs;

  // Default operand/result width of the divider.
  localparam int unsigned DIV_WIDTH = 32;

  // Divider FSM state encoding.
  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_BUSY = 2'b01;
  localparam logic [1:0] DIV_DONE = 2'b10;

  // Divide by zero is defined, not trapped: LO is all ones (DIV0_LO = '1) and
  // HI passes the raw dividend through (DIV0_HI = dividend).
  localparam logic DIV0_LO_BIT = 1'b1;

endpackage

// File: rtl/div_abs.sv
// Magnitude / conditional negate helper for the divider.
module div_abs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             signed_div,
  input  logic             force_neg,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  logic [WIDTH-1:0] negated;

  // Two's-complement negate; the most negative value maps to itself.
  always_comb begin
    negated = ~value + {{(WIDTH - 1){1'b0}}, 1'b1};
    sign    = signed_div & value[WIDTH-1];
    mag     = (sign | force_neg) ? negated : value;
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider; HI = remainder, LO = quotient.
module div_unit
  import cpu_defs::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_div,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             hold,
  input  logic             annul,
  output logic             div_ready,
  output logic             div_busy,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             neg_quo_q, neg_rem_q;
  logic             ready_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_sign, b_sign;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] rem_fix, quo_fix;
  logic             last_iter, div_zero;
  logic             unused_fix_sign;
  logic             fix_quo_sign, fix_rem_sign;

  div_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value      (dividend),
    .signed_div (signed_div),
    .force_neg  (1'b0),
    .mag        (a_mag),
    .sign       (a_sign)
  );

  div_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value      (divisor),
    .signed_div (signed_div),
    .force_neg  (1'b0),
    .mag        (b_mag),
    .sign       (b_sign)
  );

  // Sign correction of the final iteration's result reuses the same negate.
  div_abs #(.WIDTH(WIDTH)) u_fix_quo (
    .value      (quo_nxt),
    .signed_div (1'b0),
    .force_neg  (neg_quo_q),
    .mag        (quo_fix),
    .sign       (fix_quo_sign)
  );

  div_abs #(.WIDTH(WIDTH)) u_fix_rem (
    .value      (rem_nxt),
    .signed_div (1'b0),
    .force_neg  (neg_rem_q),
    .mag        (rem_fix),
    .sign       (fix_rem_sign)
  );

  // Correction instances never assert sign (signed_div tied low).
  assign unused_fix_sign = fix_quo_sign ^ fix_rem_sign;

  // One restoring iteration: shift {rem, quo} left, trial-subtract divisor.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
    end
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    div_zero  = (divisor == '0);
  end

  // Next-state logic; annul forces IDLE from any state and beats start_div.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (start_div) state_d = div_zero ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (last_iter) state_d = DIV_DONE;
      DIV_DONE: if (!hold)     state_d = DIV_IDLE;
      default:                 state_d = DIV_IDLE;
    endcase
    if (annul) state_d = DIV_IDLE;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q <= state_d;
      // Ready is high exactly while the next state is DONE.
      ready_q <= (state_d == DIV_DONE);
      if (annul) begin
        cnt_q <= '0;
      end else begin
        unique case (state_q)
          DIV_IDLE: begin
            if (start_div) begin
              rem_q     <= '0;
              quo_q     <= a_mag;
              dvs_q     <= b_mag;
              neg_quo_q <= a_sign ^ b_sign;
              neg_rem_q <= a_sign;
              cnt_q     <= '0;
              if (div_zero) begin
                hi_q <= dividend;
                lo_q <= {WIDTH{DIV0_LO_BIT}};
              end
            end
          end
          DIV_BUSY: begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_iter) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign div_ready = ready_q;
  assign div_busy  = (state_q == DIV_BUSY);
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes model results, monitor checks.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start_div, signed_div, hold, annul;
  logic [31:0] dividend, divisor;
  logic        div_ready, div_busy;
  logic [31:0] hi_out, lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] last_hi = '0, last_lo = '0;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_div  (start_div),
    .signed_div (signed_div),
    .dividend   (dividend),
    .divisor    (divisor),
    .hold       (hold),
    .annul      (annul),
    .div_ready  (div_ready),
    .div_busy   (div_busy),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: divide magnitudes with wide unsigned arithmetic, then apply signs.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned ua, ub, q, r;
    bit na, nb;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    na = sgn && a[31];
    nb = sgn && b[31];
    ua = na ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
    ub = nb ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
    q  = ua / ub;
    r  = ua % ub;
    if (na ^ nb) q = (64'h1_0000_0000 - q) & 64'hFFFF_FFFF;
    if (na)      r = (64'h1_0000_0000 - r) & 64'hFFFF_FFFF;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: pop on each rising div_ready, check result held while ready stays high.
  initial begin
    exp_t cur;
    logic ready_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ready_prev = 1'b0;
      end else begin
        if (div_ready && !ready_prev) begin
          if (exp_q.size() == 0) begin
            chk("spurious_ready", 32'(div_ready), 32'd0);
          end else begin
            cur = exp_q.pop_front();
            chk("lo", lo_out, cur.lo);
            chk("hi", hi_out, cur.hi);
            chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
            chk("busy_in_done", 32'(div_busy), 32'd0);
          end
        end else if (div_ready) begin
          chk("lo_held", lo_out, cur.lo);
          chk("hi_held", hi_out, cur.hi);
        end
        ready_prev = div_ready;
      end
    end
  end

  // Issue one divide with start held; ready expected 33 cycles after the
  // accepting IDLE cycle (32 edges later), or in the next cycle for divisor 0.
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int hold_n);
    exp_t        e;
    logic [63:0] r;
    int          waited;
    r     = ref_div(sgn, a, b);
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.lat = (b == 0) ? 0 : 32;
    e.acc = cyc + 1;
    exp_q.push_back(e);
    start_div  = 1'b1;
    signed_div = sgn;
    dividend   = a;
    divisor    = b;
    hold       = 1'b0;
    waited     = 0;
    do begin
      @(negedge clk);
      waited++;
      // Operands wander after acceptance; only captured values may matter.
      dividend   = $urandom;
      divisor    = $urandom;
      signed_div = 1'($urandom_range(0, 1));
    end while (!div_ready && waited < 40);
    if (!div_ready) begin
      chk("ready_timeout", 32'(div_ready), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start_div = 1'b0;
      exp_q.delete();
      return;
    end
    for (int i = 0; i < hold_n; i++) begin
      hold = 1'b1;
      @(negedge clk);
    end
    hold = 1'b0;
    @(negedge clk);
    // start_div was still high in the last DONE cycle: no restart allowed.
    chk("idle_busy", 32'(div_busy), 32'd0);
    chk("idle_ready", 32'(div_ready), 32'd0);
    start_div = 1'b0;
    last_hi   = e.hi;
    last_lo   = e.lo;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    rst = 1'b1; start_div = 1'b0; signed_div = 1'b0; hold = 1'b0; annul = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(div_ready), 32'd0);
    chk("rst_busy", 32'(div_busy), 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    @(negedge clk);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 0);    // back-to-back
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(1'b0, 32'h1234, 32'd0, 0);
    do_div(1'b1, 32'hFFFF_FF00, 32'd3, 5);     // hold in DONE

    // Annul mid-divide: outputs keep previous result, then a fresh divide.
    start_div = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd7;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0; start_div = 1'b0;
    chk("annul_ready", 32'(div_ready), 32'd0);
    chk("annul_busy", 32'(div_busy), 32'd0);
    chk("annul_hi", hi_out, last_hi);
    chk("annul_lo", lo_out, last_lo);
    do_div(1'b1, 32'hDEAD_BEEF, 32'h0000_1357, 0);

    // Annul beats start_div in IDLE.
    start_div = 1'b1; annul = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    chk("annul_start_busy", 32'(div_busy), 32'd0);
    chk("annul_start_ready", 32'(div_ready), 32'd0);
    start_div = 1'b0; annul = 1'b0;
    @(negedge clk);

    // Reset together with annul mid-divide.
    start_div = 1'b1; signed_div = 1'b1; dividend = 32'h7654_3210; divisor = 32'd5;
    repeat (21) @(negedge clk);
    rst = 1'b1; annul = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(div_ready), 32'd0);
    chk("midrst_busy", 32'(div_busy), 32'd0);
    chk("midrst_hi", hi_out, 32'd0);
    chk("midrst_lo", lo_out, 32'd0);
    rst = 1'b0; annul = 1'b0; start_div = 1'b0;
    last_hi = '0; last_lo = '0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
        3: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : b; end
        4: a = $urandom_range(0, 100);
        default: ;
      endcase
      do_div(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
